// File: rtl/data_cache_pkg.sv
// Shared widths, cache geometry, FSM encodings and an address helper for data_cache.
// Optional prefetch support is controlled by the DCACHE_PREFETCH_EN macro.
`ifndef Addr_Width
`define Addr_Width 32
`endif
`ifndef Data_Width
`define Data_Width 32
`endif
`ifndef Addr_Mask
`define Addr_Mask 32'hFFFF_FFFC
`endif

package data_cache_pkg;
    localparam int ADDR_W         = `Addr_Width;
    localparam int DATA_W         = `Data_Width;
    localparam int LINE_NUM       = 16;
    localparam int WORDS_PER_LINE = 4;
    localparam int IDX_W          = $clog2(LINE_NUM);
    localparam int OFF_W          = $clog2(WORDS_PER_LINE);
    localparam int TAG_W          = ADDR_W - IDX_W - OFF_W - 2;
    localparam int OFF_LO         = 2;
    localparam int IDX_LO         = OFF_LO + OFF_W;
    localparam int TAG_LO         = IDX_LO + IDX_W;

    typedef enum logic [1:0] {
        DC_IDLE     = 2'd0,
        DC_FILL_REQ = 2'd1,
        DC_FILL     = 2'd2,
        DC_WRITE    = 2'd3
    } dc_state_e;

    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(WORDS_PER_LINE * 4 - 1);
    endfunction
endpackage

// File: rtl/dcache_line_array.sv
// Valid/tag/data flops for the direct-mapped cache with combinational lookup,
// a fill-word write port and a byte-masked store-update port.
module dcache_line_array
    import data_cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_hit,
    output logic [DATA_W-1:0] rd_data,
    input  logic [ADDR_W-1:0] probe_addr,
    output logic              probe_hit,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic              fill_we,
    input  logic [OFF_W-1:0]  fill_off,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              fill_done,
    input  logic              st_we,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [3:0]        st_mask
);
    logic [LINE_NUM-1:0] valid;
    logic [TAG_W-1:0]    tags  [LINE_NUM];
    logic [DATA_W-1:0]   words [LINE_NUM][WORDS_PER_LINE];

    logic [IDX_W-1:0] rd_idx, probe_idx, fill_idx, st_idx;
    logic [OFF_W-1:0] rd_off, st_off;
    logic             unused_lsbs;

    assign rd_idx    = rd_addr[IDX_LO +: IDX_W];
    assign rd_off    = rd_addr[OFF_LO +: OFF_W];
    assign probe_idx = probe_addr[IDX_LO +: IDX_W];
    assign fill_idx  = fill_addr[IDX_LO +: IDX_W];
    assign st_idx    = st_addr[IDX_LO +: IDX_W];
    assign st_off    = st_addr[OFF_LO +: OFF_W];
    assign unused_lsbs = ^{rd_addr[1:0], probe_addr[1:0], fill_addr[IDX_LO-1:0], st_addr[1:0]};

    assign rd_hit    = valid[rd_idx] && (tags[rd_idx] == rd_addr[ADDR_W-1:TAG_LO]);
    assign rd_data   = words[rd_idx][rd_off];
    assign probe_hit = valid[probe_idx] && (tags[probe_idx] == probe_addr[ADDR_W-1:TAG_LO]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else begin
            if (fill_start) valid[fill_idx] <= 1'b0;
            if (fill_done)  valid[fill_idx] <= 1'b1;
        end
    end

    // Tag and data storage is deliberately left unreset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (fill_start) tags[fill_idx] <= fill_addr[ADDR_W-1:TAG_LO];
        if (fill_we)    words[fill_idx][fill_off] <= fill_data;
        if (st_we) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (st_mask[b]) words[st_idx][st_off][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end
endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-through no-write-allocate L1 data cache with one outstanding memory transaction.
// Define DCACHE_PREFETCH_EN to enable the single-entry prefetch hint register.
module data_cache
    import data_cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              dcache_prefetch,
    input  logic [ADDR_W-1:0] dcache_pre_addr,
    input  logic              dcache_read,
    input  logic [ADDR_W-1:0] dcache_read_addr,
    output logic              dcache_read_done,
    output logic [DATA_W-1:0] dcache_read_data,
    input  logic              commit_write,
    input  logic [ADDR_W-1:0] commit_addr,
    input  logic [DATA_W-1:0] commit_data,
    input  logic [3:0]        commit_mask,
    output logic              commit_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);
    dc_state_e         state, state_nx;
    logic [OFF_W-1:0]  beat;
    logic [ADDR_W-1:0] fill_addr, wr_addr, probe_addr, pre_addr_eff;
    logic [DATA_W-1:0] wr_data;
    logic [3:0]        wr_mask;
    logic              rd_hit, probe_hit, read_miss, idle_arb;
    logic              pre_valid, pre_take, pre_fill;
    logic              fill_start, fill_we, fill_done, st_we;

    assign idle_arb  = (state == DC_IDLE) && rst;
    assign read_miss = dcache_read && !rd_hit;
    assign pre_take  = idle_arb && !commit_write && !read_miss && pre_valid;
    assign pre_fill  = pre_take && !probe_hit;
    assign probe_addr = commit_write ? commit_addr : pre_addr_eff;

`ifdef DCACHE_PREFETCH_EN
    logic              pre_pend;
    logic [ADDR_W-1:0] pre_addr_q;

    assign pre_valid    = pre_pend;
    assign pre_addr_eff = pre_addr_q;

    // A hint arriving in the cycle the old one is consumed wins and stays pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_pend   <= 1'b0;
            pre_addr_q <= '0;
        end else begin
            if (pre_take) pre_pend <= 1'b0;
            if (dcache_prefetch) begin
                pre_pend   <= 1'b1;
                pre_addr_q <= dcache_pre_addr;
            end
        end
    end
`else
    logic unused_prefetch;
    assign unused_prefetch = ^{dcache_prefetch, dcache_pre_addr};
    assign pre_valid       = 1'b0;
    assign pre_addr_eff    = '0;
`endif

    dcache_line_array u_lines (
        .clk        (clk),
        .rst_n      (rst),
        .rd_addr    (dcache_read_addr),
        .rd_hit     (rd_hit),
        .rd_data    (dcache_read_data),
        .probe_addr (probe_addr),
        .probe_hit  (probe_hit),
        .fill_start (fill_start),
        .fill_addr  (fill_addr),
        .fill_we    (fill_we),
        .fill_off   (beat),
        .fill_data  (mem_rdata),
        .fill_done  (fill_done),
        .st_we      (st_we),
        .st_addr    (commit_addr),
        .st_data    (commit_data),
        .st_mask    (commit_mask)
    );

    assign dcache_read_done = dcache_read && rd_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= DC_IDLE;
            beat      <= '0;
            fill_addr <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_mask   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                DC_IDLE: begin
                    if (commit_write) begin
                        wr_addr <= commit_addr;
                        wr_data <= commit_data;
                        wr_mask <= commit_mask;
                    end else if (read_miss) begin
                        fill_addr <= line_base(dcache_read_addr);
                    end else if (pre_fill) begin
                        fill_addr <= line_base(pre_addr_eff);
                    end
                end
                DC_FILL_REQ: if (mem_ready)  beat <= '0;
                DC_FILL:     if (mem_rvalid) beat <= beat + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            DC_IDLE: begin
                if (commit_write)   state_nx = DC_WRITE;
                else if (read_miss) state_nx = DC_FILL_REQ;
                else if (pre_fill)  state_nx = DC_FILL_REQ;
            end
            DC_FILL_REQ: if (mem_ready) state_nx = DC_FILL;
            DC_FILL:     if (mem_rvalid && beat == OFF_W'(WORDS_PER_LINE - 1)) state_nx = DC_IDLE;
            DC_WRITE:    if (mem_ready) state_nx = DC_IDLE;
            default:     state_nx = DC_IDLE;
        endcase
    end

    always_comb begin
        commit_ready = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_wmask    = '0;
        fill_start   = 1'b0;
        fill_we      = 1'b0;
        fill_done    = 1'b0;
        st_we        = 1'b0;
        case (state)
            DC_IDLE: begin
                commit_ready = rst;
                st_we        = idle_arb && commit_write && probe_hit;
            end
            DC_FILL_REQ: begin
                mem_req    = 1'b1;
                mem_addr   = fill_addr;
                fill_start = mem_ready;
            end
            DC_FILL: begin
                fill_we   = mem_rvalid;
                fill_done = mem_rvalid && (beat == OFF_W'(WORDS_PER_LINE - 1));
            end
            DC_WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wr_addr;
                mem_wdata = wr_data;
                mem_wmask = wr_mask;
            end
            default: ;
        endcase
    end
endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-through, no-write-allocate L1 data cache.
- Sits directly downstream of the load/store unit. It serves that unit's word-aligned read requests and prefetch hints, and accepts committed stores from the ROB.
- Misses and stores go to the memory port through a single outstanding-transaction FSM.

Parameters:
- LINE_NUM, 16, number of cache lines (power of 2); IDX_W = log2(LINE_NUM).
- WORDS_PER_LINE, 4, 32-bit words per line (power of 2); OFF_W = log2(WORDS_PER_LINE).
- TAG_W, `Addr_Width-IDX_W-OFF_W-2, tag width; address layout is {tag, index, word offset, 2'b00}.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-low reset.
- dcache_prefetch, input, 1, prefetch hint pulse.
- dcache_pre_addr, input, `Addr_Width, prefetch byte address.
- dcache_read, input, 1, load request, level-held until done.
- dcache_read_addr, input, `Addr_Width, word-aligned load address, stable while dcache_read is high.
- dcache_read_done, output, 1, load data valid this cycle.
- dcache_read_data, output, `Data_Width, load word.
- commit_write, input, 1, committed store valid.
- commit_addr, input, `Addr_Width, store word address.
- commit_data, input, `Data_Width, store data, already lane-aligned.
- commit_mask, input, 4, byte enables.
- commit_ready, output, 1, store accepted when high together with commit_write.
- mem_req, output, 1, memory request, held until mem_ready.
- mem_we, output, 1, 1 = write, 0 = line read.
- mem_addr, output, `Addr_Width, store word address, or line base address for reads.
- mem_wdata, output, `Data_Width, store data.
- mem_wmask, output, 4, store byte enables.
- mem_ready, input, 1, memory accepts the request this cycle.
- mem_rvalid, input, 1, one fill beat valid.
- mem_rdata, input, `Data_Width, fill beat data, in ascending word order.

Behaviour:
- Reset (async, rst low):
  - All valid bits cleared, state IDLE, beat counter 0, prefetch pending cleared.
  - mem_req, mem_we and commit_ready are 0; mem_addr, mem_wdata and mem_wmask are 0.
  - Data and tag arrays are not cleared.
  - Reset asserted mid-fill abandons the fill. The line stays invalid, and any beats still arriving afterward are ignored while in IDLE.
- Hit: valid[idx] && tag[idx]==addr tag. Data and tag arrays are flops, so lookup is combinational.
- Read hit:
  - dcache_read_done = dcache_read && hit, in the same cycle, in any state.
  - dcache_read_data = line word at the addressed offset.
  - Combinational done is mandatory: the requester samples done and advances its queue on the next edge.
- Read miss: dcache_read_done stays 0 until the line is filled and the lookup hits. Done is never a registered pulse.
- States: IDLE, FILL_REQ, FILL, WRITE.
- IDLE arbitration, highest priority first:
  1. commit_write: commit_ready=1 combinationally in IDLE. Latch the store; if it hits, update the cached word under commit_mask. Go to WRITE.
  2. dcache_read miss: latch the line base address. Go to FILL_REQ.
  3. Pending prefetch that misses: go to FILL_REQ with its address. A pending prefetch that hits is dropped.
- FILL_REQ:
  - mem_req=1, mem_we=0, mem_addr=line base.
  - On mem_ready: clear valid[idx], write tag, go to FILL with beat=0.
- FILL:
  - Each mem_rvalid writes word[beat] and increments beat.
  - On the final beat (beat==WORDS_PER_LINE-1): set valid and return to IDLE.
  - Miss latency from request to done = arbitration cycle + mem_ready wait + WORDS_PER_LINE beats + 1.
- WRITE: mem_req=1, mem_we=1, with address, data and mask from the latch. On mem_ready go to IDLE.
- Stores never allocate a line on miss.
- commit_ready=0 outside IDLE.
- Prefetch register:
  - One entry; a new hint overwrites an older pending one.
  - Cleared when its fill is issued or when it is dropped as a hit.
  - A hint arriving in the same cycle it is consumed is retained.
- Simultaneous store and read in IDLE:
  - A read hit is still served that cycle.
  - The store's hit-update is visible from the next cycle.
  - A read miss waits until the store finishes.
- A read to a line currently in FILL misses (valid was cleared) until the fill completes.

Optional Feature:
- DCACHE_PREFETCH_EN defined: prefetch register and arbitration slot behave as above.
- Not defined: dcache_prefetch and dcache_pre_addr are ignored, no prefetch fills are ever issued, and the pending register is removed.

Decomposition:
- Shared defines.v: `Addr_Width, `Data_Width, `Addr_Mask, and the FSM state encodings (DC_IDLE, DC_FILL_REQ, DC_FILL, DC_WRITE).
- One sub-module, dcache_line_array:
  - Holds valid, tag and data flops.
  - Provides a combinational lookup port, a fill-word write port and a masked store-update port.

Test Plan:
- Cold read at 0x100: FILL_REQ with mem_addr=0x100. After mem_ready and 4 beats (0xA0..0xA3), done=1 with data 0xA0. Next read 0x10C hits the same cycle with data 0xA3.
- Store 0x104, data 0x0000BEEF, mask 4'b0011 on the valid line: commit_ready=1, then WRITE with mem_wmask=0011. A read of 0x104 returns 0x??? with the low half 0xBEEF merged into 0xA1.
- Store to uncached 0x2000: memory write issued; a following read of 0x2000 still misses (no allocate).
- Prefetch 0x300 while idle: fill issued with no read pending. A later read of 0x300 hits immediately. With the macro undefined, the same read misses.
- Store and read-miss asserted in the same cycle: WRITE completes first, then FILL_REQ. Read done arrives only after the fill.
- rst low during beat 2 of a fill: state goes to IDLE and mem_req=0. A read of that line then misses and refetches.
